// File: rtl/sdram_arb.sv
// ---------------------------------------------------------------------------
// sdram_arb -- round-robin arbiter that funnels NUM_REQ command ports into a
// single sdram_core command interface, one command outstanding at a time.
//
// Ports
//   clk, rst_n        clock (rising edge) and async active-low reset
//   req_valid/ready   per-requester handshake; ready is a one-cycle grant pulse
//   req_we/addr/      per-requester command fields, flattened; slice i sits at
//   wdata/wstrb       [i*W +: W]
//   rsp_valid         one-cycle completion pulse to the owning requester
//   rsp_rdata         shared read data, registered, held until next completion
//   cmd_*             command to sdram_core (valid/ready handshake)
//   cmd_done/rdata    completion strobe and read data from sdram_core
//   busy              high whenever the FSM is not idle
//   grant_id          index of the current or most recent grant
// ---------------------------------------------------------------------------
module sdram_arb #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 24,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]     req_wdata,
    input  logic [NUM_REQ*4-1:0]      req_wstrb,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic                      cmd_we,
    output logic [ADDR_W-1:0]         cmd_addr,
    output logic [31:0]               cmd_wdata,
    output logic [3:0]                cmd_wstrb,
    input  logic                      cmd_done,
    input  logic [31:0]               cmd_rdata,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  arm_q;
    logic [ID_W-1:0]       last_grant_q;
    logic [ID_W-1:0]       grant_id_q;
    logic                  cmd_we_q;
    logic [ADDR_W-1:0]     cmd_addr_q;
    logic [31:0]           cmd_wdata_q;
    logic [3:0]            cmd_wstrb_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [31:0]           rsp_rdata_q;

    logic                  win_found;
    logic [ID_W-1:0]       win_idx;
    logic [ID_W:0]         cand;
    logic                  grant;

    // Round-robin search starting one past the last grant. cand carries one
    // spare bit so last_grant + NUM_REQ never overflows before the wrap.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    // arm_q holds off grants until the first edge after reset release, so
    // the combinational req_ready cannot rise while still between edges.
    assign grant = (state_q == ST_IDLE) && arm_q && win_found;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of process order.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant)     state_d = ST_ISSUE;
            ST_ISSUE: if (cmd_ready) state_d = ST_WAIT;
            ST_WAIT:  if (cmd_done)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
        cmd_valid = (state_q == ST_ISSUE);
        busy      = (state_q != ST_IDLE);
    end

    // Command latch, grant bookkeeping and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q        <= 1'b0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_wstrb_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            arm_q <= 1'b1;
            if (grant) begin
                last_grant_q <= win_idx;
                grant_id_q   <= win_idx;
                cmd_we_q     <= req_we[win_idx];
                cmd_addr_q   <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                cmd_wdata_q  <= req_wdata[int'(win_idx)*32 +: 32];
                cmd_wstrb_q  <= req_wstrb[int'(win_idx)*4 +: 4];
            end
            // Completions outside WAIT are stray and must not reach a requester.
            rsp_valid_q <= '0;
            if (state_q == ST_WAIT && cmd_done) begin
                rsp_valid_q[grant_id_q] <= 1'b1;
                rsp_rdata_q             <= cmd_rdata;
            end
        end
    end

    assign grant_id  = grant_id_q;
    assign cmd_we    = cmd_we_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;
    assign cmd_wstrb = cmd_wstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
